// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: D = |A - B| using nines-complement addition,
// one digit per clock. A negative result is recovered by a second tens-complement pass.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   D,
    output logic                  neg,
    output logic                  invalid,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, d_q, d_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            neg_q, neg_d;
    logic            invalid_q, invalid_d;

    logic [2*DIGITS-1:0] digit_bad;
    logic [3:0]          a_dig, b_dig, d_dig, res_dig;
    logic [4:0]          sum;
    logic                sum_carry;
    logic                last_dig;

    // Operand digits are checked straight off the inputs, in the same cycle they are latched.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign digit_bad[2*gi]   = (A[4*gi +: 4] > 4'd9);
            assign digit_bad[2*gi+1] = (B[4*gi +: 4] > 4'd9);
        end
    endgenerate

    always_comb begin
        a_dig    = a_q[{idx_q, 2'b00} +: 4];
        b_dig    = b_q[{idx_q, 2'b00} +: 4];
        d_dig    = d_q[{idx_q, 2'b00} +: 4];
        last_dig = (idx_q == IW'(DIGITS - 1));
        // SUB adds the nines complement of B; COMP takes the nines complement of D itself.
        if (state_q == COMP)
            sum = (5'd9 - {1'b0, d_dig}) + {4'b0, carry_q};
        else
            sum = {1'b0, a_dig} + (5'd9 - {1'b0, b_dig}) + {4'b0, carry_q};
        sum_carry = (sum > 5'd9);
        res_dig   = sum_carry ? 4'(sum - 5'd10) : sum[3:0];
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        invalid_d = invalid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    d_d     = '0;
                    idx_d   = '0;
                    neg_d   = 1'b0;
                    carry_d = 1'b1;
                    if (|digit_bad) begin
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        invalid_d = 1'b0;
                        state_d   = SUB;
                    end
                end
            end
            SUB: begin
                d_d[{idx_q, 2'b00} +: 4] = res_dig;
                carry_d = sum_carry;
                idx_d   = idx_q + 1'b1;
                if (last_dig) begin
                    idx_d = '0;
                    // No end-around carry means A < B and D holds a complemented result.
                    if (sum_carry) begin
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        neg_d   = 1'b1;
                        carry_d = 1'b1;
                        state_d = COMP;
                    end
                end
            end
            COMP: begin
                d_d[{idx_q, 2'b00} +: 4] = res_dig;
                carry_d = sum_carry;
                idx_d   = idx_q + 1'b1;
                if (last_dig) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_q       <= d_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            neg_q     <= neg_d;
            invalid_q <= invalid_d;
        end
    end

    assign D       = d_q;
    assign neg     = neg_q;
    assign invalid = invalid_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4): vector table plus hand-written
// sequences for ignored start, back-to-back requests and mid-operation reset.
module tb_bcd_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] A, B, D;
    logic        start, neg, invalid, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        logic        exp_neg;
        logic        exp_inv;
        int          exp_lat;   // negedge index (1 = cycle after E0) where done is seen
    } vec_t;

    vec_t vecs[8];

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .start(start),
        .D(D), .neg(neg), .invalid(invalid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one start pulse, then watch busy/done until completion or timeout.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int busy_drop;
        lat = 0;
        busy_drop = 0;
        @(negedge clk);
        A = v.a; B = v.b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!busy) busy_drop++;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " busy"}, busy_drop, 0);
        chk({tag, " D"}, D, v.exp_d);
        chk({tag, " neg"}, neg, v.exp_neg);
        chk({tag, " invalid"}, invalid, v.exp_inv);
        @(negedge clk);
        chk({tag, " done pulse width"}, done, 0);
        chk({tag, " idle after"}, busy, 0);
        chk({tag, " D held"}, D, v.exp_d);
        $display("op %s: A=%h B=%h -> D=%h neg=%0d invalid=%0d lat=%0d",
                 tag, v.a, v.b, D, neg, invalid, lat);
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done, second_done;
        logic busy6;

        vecs[0] = '{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9};
        vecs[2] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5};
        vecs[3] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
        vecs[4] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
        vecs[5] = '{16'h0050, 16'h0020, 16'h0030, 1'b0, 1'b0, 5};
        vecs[6] = '{16'h0100, 16'h0250, 16'h0150, 1'b1, 1'b0, 9};
        vecs[7] = '{16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0, 5};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #3;
        chk("reset D", D, 0);
        chk("reset neg", neg, 0);
        chk("reset invalid", invalid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Start pulses with different operands while SUB/DONE are running are ignored.
        @(negedge clk);
        A = 16'h1234; B = 16'h0567; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 2) begin A = 16'h0000; B = 16'h0001; start = 1'b1; end
            if (c == 3) start = 1'b0;
            if (done) begin
                lat = c; ndone++; start = 1'b1;   // also pulse while in DONE
                break;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignore latency", lat, 5);
        chk("ignore done count", ndone, 1);
        chk("ignore D", D, 16'h0667);
        chk("ignore neg", neg, 0);
        $display("op ignore-start: D=%h neg=%0d lat=%0d dones=%0d", D, neg, lat, ndone);

        // start held high: back-to-back operations with one IDLE cycle between.
        @(negedge clk);
        A = 16'h0050; B = 16'h0020; start = 1'b1;
        first_done = 0; second_done = 0; busy6 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 6) busy6 = busy;
            if (done && first_done == 0) first_done = c;
            else if (done) second_done = c;
            if (c == 12) start = 1'b0;
        end
        chk("b2b first done", first_done, 5);
        chk("b2b idle gap", busy6, 0);
        chk("b2b second done", second_done, 11);
        chk("b2b D", D, 16'h0030);
        @(negedge clk);
        chk("b2b stops", busy, 0);
        $display("op back-to-back: dones at %0d and %0d D=%h", first_done, second_done, D);

        // Reset in the third SUB cycle aborts the operation immediately.
        @(negedge clk);
        A = 16'h1234; B = 16'h0567; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort D", D, 0);
        chk("abort neg", neg, 0);
        chk("abort invalid", invalid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort held", ndone, 0);
        rst_n = 1'b1;
        $display("op abort: D=%h busy=%0d done=%0d", D, busy, done);
        run_vec(vecs[5], "after-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
